// File: rtl/iquant_pkg.sv
// Shared constants, read FSM states and zigzag-to-raster table for the IQ block feeder.
// Optional feature macro used by the top: IQUANT_ZIGZAG_EN.
package iquant_pkg;

    localparam int COEF_W   = 12;
    localparam int ADDR_W   = 6;
    localparam int NUM_COEF = 64;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_e;

    // Entry k is the raster position of zigzag scan index k.
    localparam logic [ADDR_W-1:0] ZZ_TO_RASTER [NUM_COEF] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [ADDR_W-1:0] zz_to_raster(input logic [ADDR_W-1:0] zz_idx);
        return ZZ_TO_RASTER[zz_idx];
    endfunction

endpackage

// File: rtl/iquant_coef_bank.sv
// One coefficient bank: 64x12 simple dual-port RAM with registered read,
// plus a written-mask that is cleared in a single cycle when the bank is released.
module iquant_coef_bank
    import iquant_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clk_en,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic signed [COEF_W-1:0] i_wdata,
    input  logic                     i_rd_en,
    input  logic [ADDR_W-1:0]        i_raddr,
    input  logic                     i_clr,
    output logic signed [COEF_W-1:0] o_rdata,
    output logic                     o_rmask
);

    logic signed [COEF_W-1:0] r_mem [NUM_COEF];
    logic signed [COEF_W-1:0] r_rdata;
    logic [NUM_COEF-1:0]      r_mask;
    logic                     r_rmask;

    // Store contents carry no reset; unwritten entries are masked to zero on read.
    always_ff @(posedge i_clk) begin
        if (i_clk_en && i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clk_en && i_rd_en) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    // Mask read uses the pre-clear value, so the final index still sees its own bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mask  <= '0;
            r_rmask <= 1'b0;
        end else if (i_clk_en) begin
            if (i_rd_en) begin
                r_rmask <= r_mask[i_raddr];
            end
            if (i_clr) begin
                r_mask <= '0;
            end else if (i_we) begin
                r_mask[i_waddr] <= 1'b1;
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_rmask = r_rmask;

endmodule

// File: rtl/iquant_block_feeder.sv
// Ping-pong coefficient collector feeding 64-sample raster blocks to the IDCT.
// Define IQUANT_ZIGZAG_EN to interpret coef_addr as a zigzag scan index.
module iquant_block_feeder
    import iquant_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     coef_wr_en,
    input  logic [ADDR_W-1:0]        coef_addr,
    input  logic signed [COEF_W-1:0] coef_level,
    input  logic                     coef_block_end,
    output logic                     coef_ready,
    output logic signed [COEF_W-1:0] iquant_level,
    output logic                     iquant_valid
);

    logic                     r_wb;
    logic                     r_rb;
    logic [1:0]               r_full;
    rd_state_e                r_state;
    logic [ADDR_W-1:0]        r_raddr;
    logic                     r_rd_vld;
    logic                     r_rd_bank;
    logic                     r_coef_ready;
    logic signed [COEF_W-1:0] r_level;
    logic                     r_valid;

    logic                     w_wr_acc;
    logic                     w_end_acc;
    logic [ADDR_W-1:0]        w_waddr;
    logic                     w_rd_en;
    logic [ADDR_W-1:0]        w_rd_addr;
    logic                     w_rd_last;
    logic [1:0]               w_full_nxt;
    logic                     w_wb_nxt;
    logic signed [COEF_W-1:0] w_rdata [2];
    logic [1:0]               w_rmask;
    logic signed [COEF_W-1:0] w_sel_level;

    assign w_wr_acc  = coef_wr_en & r_coef_ready;
    assign w_end_acc = coef_block_end & r_coef_ready;

`ifdef IQUANT_ZIGZAG_EN
    assign w_waddr = zz_to_raster(coef_addr);
`else
    assign w_waddr = coef_addr;
`endif

    // Address 0 is fetched on the IDLE->STREAM edge so the first sample lands two cycles after block_end.
    assign w_rd_en   = (r_state == ST_STREAM) | ((r_state == ST_IDLE) & r_full[r_rb]);
    assign w_rd_addr = (r_state == ST_IDLE) ? {ADDR_W{1'b0}} : r_raddr;
    assign w_rd_last = (r_state == ST_STREAM) & (r_raddr == 6'd63);

    assign w_full_nxt[0] = (r_full[0] & ~(w_rd_last & (r_rb == 1'b0))) | (w_end_acc & (r_wb == 1'b0));
    assign w_full_nxt[1] = (r_full[1] & ~(w_rd_last & (r_rb == 1'b1))) | (w_end_acc & (r_wb == 1'b1));
    assign w_wb_nxt      = r_wb ^ w_end_acc;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_bank
            iquant_coef_bank u_bank (
                .i_clk    (clk),
                .i_rst    (rst),
                .i_clk_en (clk_en),
                .i_we     (w_wr_acc & (r_wb == g[0])),
                .i_waddr  (w_waddr),
                .i_wdata  (coef_level),
                .i_rd_en  (w_rd_en & (r_rb == g[0])),
                .i_raddr  (w_rd_addr),
                .i_clr    (w_rd_last & (r_rb == g[0])),
                .o_rdata  (w_rdata[g]),
                .o_rmask  (w_rmask[g])
            );
        end
    endgenerate

    assign w_sel_level = w_rmask[r_rd_bank] ? w_rdata[r_rd_bank] : 12'sd0;

    // Ready is derived from next-state flags so a full bank is never reopened for a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb         <= 1'b0;
            r_rb         <= 1'b0;
            r_full       <= 2'b00;
            r_coef_ready <= 1'b1;
        end else if (clk_en) begin
            r_wb         <= w_wb_nxt;
            r_rb         <= r_rb ^ w_rd_last;
            r_full       <= w_full_nxt;
            r_coef_ready <= ~w_full_nxt[w_wb_nxt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_raddr <= 6'd0;
        end else if (clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_full[r_rb]) begin
                        r_state <= ST_STREAM;
                        r_raddr <= 6'd1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_raddr <= 6'd0;
                    end
                end
                ST_STREAM: begin
                    if (r_raddr == 6'd63) begin
                        r_raddr <= 6'd0;
                        r_state <= r_full[~r_rb] ? ST_STREAM : ST_IDLE;
                    end else begin
                        r_raddr <= r_raddr + 6'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_raddr <= 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_vld  <= 1'b0;
            r_rd_bank <= 1'b0;
            r_level   <= 12'sd0;
            r_valid   <= 1'b0;
        end else if (clk_en) begin
            r_rd_vld  <= w_rd_en;
            r_rd_bank <= r_rb;
            r_level   <= r_rd_vld ? w_sel_level : 12'sd0;
            r_valid   <= r_rd_vld;
        end
    end

    assign coef_ready   = r_coef_ready;
    assign iquant_level = r_level;
    assign iquant_valid = r_valid;

endmodule

// File: tb/tb_iquant_block_feeder.sv
// Randomized self-checking bench for iquant_block_feeder against a block-level reference model.
module tb_iquant_block_feeder;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_en;
    logic              coef_wr_en;
    logic [5:0]        coef_addr;
    logic signed [11:0] coef_level;
    logic              coef_block_end;
    logic              coef_ready;
    logic signed [11:0] iquant_level;
    logic              iquant_valid;

    int checks = 0;
    int errors = 0;
    int cur [64];
    int exp_q [$];
    int zz_map [64];

    iquant_block_feeder dut (
        .clk            (clk),
        .rst            (rst),
        .clk_en         (clk_en),
        .coef_wr_en     (coef_wr_en),
        .coef_addr      (coef_addr),
        .coef_level     (coef_level),
        .coef_block_end (coef_block_end),
        .coef_ready     (coef_ready),
        .iquant_level   (iquant_level),
        .iquant_valid   (iquant_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zigzag order built by walking anti-diagonals, alternating direction.
    task automatic build_zigzag();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz_map[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz_map[k] = r * 8 + (s - r); k++; end
            end
        end
    endtask

    function automatic int raster_of(input int a);
`ifdef IQUANT_ZIGZAG_EN
        return zz_map[a];
`else
        return a;
`endif
    endfunction

    task automatic model_close();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(cur[i]);
            cur[i] = 0;
        end
    endtask

    task automatic wr_cycle(input int a, input int v);
        coef_wr_en = 1'b1; coef_addr = a[5:0]; coef_level = v[11:0];
        step();
        coef_wr_en = 1'b0;
        cur[raster_of(a)] = v;
    endtask

    task automatic close_block(input logic with_wr, input int a, input int v, input logic accept);
        coef_block_end = 1'b1; coef_wr_en = with_wr; coef_addr = a[5:0]; coef_level = v[11:0];
        step();
        coef_block_end = 1'b0; coef_wr_en = 1'b0;
        if (accept) begin
            if (with_wr) cur[raster_of(a)] = v;
            model_close();
        end
    endtask

    task automatic rand_writes(input int n);
        for (int i = 0; i < n; i++) begin
            wr_cycle($urandom_range(0, 63), int'($urandom_range(0, 4095)) - 2048);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b1; coef_wr_en = 1'b0; coef_block_end = 1'b0;
        coef_addr = 6'd0; coef_level = 12'sd0;
        step(); step();
        checks++; if (iquant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", iquant_valid); end
        checks++; if (iquant_level !== 12'sd0) begin errors++; $display("FAIL reset_level: got %0d want 0", iquant_level); end
        checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", coef_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_empty_block();
        logic signed [11:0] e;
        close_block(1'b0, 0, 0, 1'b1);
        checks++; if (iquant_valid !== 1'b0) begin errors++; $display("FAIL empty_lat_n: got %b want 0", iquant_valid); end
        step();
        checks++; if (iquant_valid !== 1'b0) begin errors++; $display("FAIL empty_lat_n1: got %b want 0", iquant_valid); end
        step();
        for (int i = 0; i < 64; i++) begin
            e = 12'(exp_q.pop_front());
            checks++;
            if (iquant_valid !== 1'b1 || iquant_level !== e || coef_ready !== 1'b1) begin
                errors++;
                $display("FAIL empty_s%0d: got v=%b l=%0d rdy=%b want v=1 l=%0d rdy=1", i, iquant_valid, iquant_level, coef_ready, e);
            end
            step();
        end
        checks++; if (iquant_valid !== 1'b0) begin errors++; $display("FAIL empty_end: got %b want 0", iquant_valid); end
    endtask

    // Covers extreme levels, zigzag index 2, repeated addresses and write-with-block_end.
    task automatic test_pattern(input int kind);
        logic signed [11:0] e;
        case (kind)
            0: begin wr_cycle(0, -2048); rand_writes(6); wr_cycle(63, 2047); close_block(1'b0, 0, 0, 1'b1); end
            1: begin wr_cycle(2, 5); close_block(1'b0, 0, 0, 1'b1); end
            2: begin wr_cycle(5, 7); wr_cycle(5, -3); close_block(1'b1, 9, 1, 1'b1); end
            default: begin rand_writes(20); close_block(1'b1, $urandom_range(0, 63), 77, 1'b1); end
        endcase
        step(); step();
        for (int i = 0; i < 64; i++) begin
            e = 12'(exp_q.pop_front());
            checks++;
            if (iquant_valid !== 1'b1 || iquant_level !== e) begin
                errors++;
                $display("FAIL pat%0d_s%0d: got v=%b l=%0d want v=1 l=%0d", kind, i, iquant_valid, iquant_level, e);
            end
            step();
        end
        checks++; if (iquant_valid !== 1'b0) begin errors++; $display("FAIL pat%0d_end: got %b want 0", kind, iquant_valid); end
    endtask

    task automatic test_back_to_back();
        logic signed [11:0] e;
        rand_writes(5);
        close_block(1'b0, 0, 0, 1'b1);
        close_block(1'b1, $urandom_range(0, 63), int'($urandom_range(0, 4095)) - 2048, 1'b1);
        checks++; if (coef_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b want 0", coef_ready); end
        close_block(1'b1, $urandom_range(0, 63), 1234, 1'b0);
        for (int i = 0; i < 128; i++) begin
            e = 12'(exp_q.pop_front());
            checks++;
            if (iquant_valid !== 1'b1 || iquant_level !== e) begin
                errors++;
                $display("FAIL b2b_s%0d: got v=%b l=%0d want v=1 l=%0d", i, iquant_valid, iquant_level, e);
            end
            if (i == 32) begin
                checks++; if (coef_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_mid: got %b want 0", coef_ready); end
            end
            if (i == 63) begin
                checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %b want 1", coef_ready); end
            end
            step();
        end
        checks++; if (iquant_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", iquant_valid); end
    endtask

    task automatic test_clk_en_and_reset();
        logic signed [11:0] e;
        rand_writes(10);
        close_block(1'b0, 0, 0, 1'b1);
        step(); step();
        for (int i = 0; i < 64; i++) begin
            e = 12'(exp_q.pop_front());
            checks++;
            if (iquant_valid !== 1'b1 || iquant_level !== e) begin
                errors++;
                $display("FAIL cken_s%0d: got v=%b l=%0d want v=1 l=%0d", i, iquant_valid, iquant_level, e);
            end
            if (i == 20) begin
                clk_en = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    checks++;
                    if (iquant_valid !== 1'b1 || iquant_level !== e) begin
                        errors++;
                        $display("FAIL cken_hold%0d: got v=%b l=%0d want v=1 l=%0d", k, iquant_valid, iquant_level, e);
                    end
                end
                clk_en = 1'b1;
            end
            step();
        end
        checks++; if (iquant_valid !== 1'b0) begin errors++; $display("FAIL cken_end: got %b want 0", iquant_valid); end

        rand_writes(8);
        close_block(1'b0, 0, 0, 1'b1);
        step(); step();
        for (int i = 0; i < 30; i++) step();
        rst = 1'b1;
        #2;
        checks++; if (iquant_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", iquant_valid); end
        checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b want 1", coef_ready); end
        step(); step();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 64; i++) cur[i] = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (iquant_valid !== 1'b0) begin errors++; $display("FAIL rst_quiet%0d: got %b want 0", i, iquant_valid); end
        end
        test_pattern(3);
    endtask

    initial begin
        build_zigzag();
        for (int i = 0; i < 64; i++) cur[i] = 0;
        test_reset();
        test_empty_block();
        test_pattern(0);
        test_pattern(1);
        test_pattern(2);
        test_back_to_back();
        test_clk_en_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
